// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle sequencer: state encoding and the latched decoder control word.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef struct packed {
    logic memtoreg;
    logic memwrite;
    logic regwrite;
    logic beq;
    logic bne;
    logic blez;
  } ctrl_t;

  function automatic logic is_branch(input ctrl_t c);
    return c.beq | c.bne | c.blez;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running wrap-around event counter with synchronous clear.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: walks IF/ID/EX/MEM/WB, gates architectural writes,
// handles SYSCALL halt/resume and memory-timeout faults.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memtoreg,
  input  logic             memwrite,
  input  logic             regwrite,
  input  logic             syscall,
  input  logic             beq,
  input  logic             bne,
  input  logic             blez,
  input  logic             jr,
  input  logic             jmp,
  input  logic             jal,
  input  logic             v0_is_10,
  input  logic             go,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_reg;
  ctrl_t            ctrl_reg;
  ctrl_t            dec_ctrl;
  logic [TMO_W-1:0] tmo_reg;
  logic             fault_reg;
  logic             tmo_expired;
  logic             jump;

  assign dec_ctrl    = '{memtoreg: memtoreg, memwrite: memwrite, regwrite: regwrite,
                         beq: beq, bne: bne, blez: blez};
  assign jump        = jmp | jr | jal;
  assign tmo_expired = (tmo_reg == TMO_W'(MEM_TIMEOUT - 1));

  // The timeout count is cleared by default so that every state entry starts at zero;
  // only the two memory-wait states keep counting while they stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IF;
      ctrl_reg  <= '0;
      tmo_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      tmo_reg <= '0;
      case (state_reg)
        ST_IF: begin
          if (imem_ack) begin
            state_reg <= ST_ID;
          end else if (tmo_expired) begin
            fault_reg <= 1'b1;
            state_reg <= ST_HALT;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        ST_ID: begin
          ctrl_reg <= dec_ctrl;
          if (syscall) begin
            state_reg <= v0_is_10 ? ST_HALT : ST_IF;
          end else if (jump) begin
            state_reg <= ST_IF;
          end else begin
            state_reg <= ST_EX;
          end
        end
        ST_EX: begin
          if (is_branch(ctrl_reg)) begin
            state_reg <= ST_IF;
          end else if (ctrl_reg.memtoreg | ctrl_reg.memwrite) begin
            state_reg <= ST_MEM;
          end else begin
            state_reg <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            state_reg <= ctrl_reg.memwrite ? ST_IF : ST_WB;
          end else if (tmo_expired) begin
            fault_reg <= 1'b1;
            state_reg <= ST_HALT;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        ST_WB: begin
          state_reg <= ST_IF;
        end
        ST_HALT: begin
          if (go && !fault_reg) begin
            state_reg <= ST_IF;
          end
        end
        default: begin
          state_reg <= ST_IF;
        end
      endcase
    end
  end

  // Write strobes qualify the current cycle (acks may land in the request cycle),
  // so they are decoded from the state register and forced low during reset.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IF:   imem_req = 1'b1;
        ST_ID: begin
          if (syscall) begin
            pc_we = ~v0_is_10;
          end else if (jump) begin
            pc_we  = 1'b1;
            reg_we = jal;
          end
        end
        ST_EX:   pc_we = is_branch(ctrl_reg);
        ST_MEM: begin
          dmem_req = 1'b1;
          pc_we    = dmem_ack & ctrl_reg.memwrite;
        end
        ST_WB: begin
          pc_we  = 1'b1;
          reg_we = ctrl_reg.regwrite;
        end
        ST_HALT: pc_we = go & ~fault_reg;
        default: pc_we = 1'b0;
      endcase
    end
  end

  assign ir_we   = imem_req & imem_ack;
  assign dmem_we = dmem_req & ctrl_reg.memwrite;
  assign halted  = (state_reg == ST_HALT);
  assign fault   = fault_reg;
  assign state   = state_reg;

  // Index 0: cycle counter (frozen in HALT); index 1: retired-instruction counter.
  logic [1:0]            cnt_en;
  logic [1:0][CNT_W-1:0] cnt_vec;

  assign cnt_en = {pc_we, (state_reg != ST_HALT)};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    perf_counter #(.W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (cnt_en[gi]),
      .cnt (cnt_vec[gi])
    );
  end

  assign cycle_cnt = cnt_vec[0];
  assign instr_cnt = cnt_vec[1];

endmodule
